bitpack_mux: RTL

Parametrised successor to the fixed 16-bit/4-channel logic-analyser bit packer. It captures up to CH_MAX digital channels on each sample tick and packs 1, 2, 4, … CH_MAX active lanes, selected at run time, LSB-first into W-bit words. It sits between the sample-rate divider (samp_vld source) and the capture FIFO/DMA writer (out_* sink). It adds a run-time lane select, 2-word output buffering with overrun detection, an end-of-session marker and abort.

---
 rtl/bitpack_mux.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bitpack_mux.sv
// bitpack_mux -- run-time configurable logic-analyser bit packer.
//
// Captures din on every accepted samp_vld and packs 2^lane_sel lanes per
// sample (clamped to CH_MAX) LSB-first into W-bit words. Completed words pass
// through a two-slot buffer (output register + pending register) to the sink.
// The final word of a session carries out_last. If a word completes while both
// slots are full and the sink is not draining, the completing sample is
// dropped and overrun is set.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, abort       session start (IDLE only) / immediate session end
//   sample_cycles      samples per session, latched at start
//   lane_sel           log2 of active lanes, latched at start
//   samp_vld, din      sample tick and channel inputs
//   out_valid/out_word/out_last, out_full   word sink handshake
//   busy, done, overrun                     session status
module bitpack_mux #(
  parameter int CH_MAX = 4,
  parameter int W      = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] sample_cycles,
  input  logic [2:0]       lane_sel,
  input  logic             samp_vld,
  input  logic [CH_MAX-1:0] din,
  output logic             out_valid,
  output logic [W-1:0]     out_word,
  output logic             out_last,
  input  logic             out_full,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int LOG2_CH = $clog2(CH_MAX);
  // CW holds values 0..W inclusive (sample counts, bit offsets, lane counts).
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [2:0]    LSEL_MAX_C = 3'(LOG2_CH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       lsel_q, lsel_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [W-1:0]     pack_q, pack_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_word_q, out_word_d;
  logic             out_last_q, out_last_d;
  logic             pend_valid_q, pend_valid_d;
  logic [W-1:0]     pend_word_q, pend_word_d;
  logic             pend_last_q, pend_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic             xfer_s;
  logic [CW-1:0]    lane_cnt_s;
  logic [CW-1:0]    word_samps_s;
  logic [W-1:0]     lane_mask_s;
  logic [W-1:0]     samp_bits_s;
  logic             can_push_s;
  logic             push_s;
  logic [W-1:0]     push_word_s;
  logic             push_last_s;
  logic             last_samp_s;

  // Lane geometry and the current sample shifted into its slot of the word.
  always_comb begin
    lane_cnt_s   = ONE_C << lsel_q;
    word_samps_s = CW'(W) >> lsel_q;
    // Shifting by the full width yields zero, so L == W gives an all-ones mask.
    lane_mask_s  = ~({W{1'b1}} << lane_cnt_s);
    samp_bits_s  = (W'(din) & lane_mask_s) << (cnt_q << lsel_q);
  end

  // Next-state, packer, two-slot buffer and status logic.
  always_comb begin
    state_d      = state_q;
    lsel_d       = lsel_q;
    rem_d        = rem_q;
    pack_d       = pack_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_last_d   = out_last_q;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    pend_last_d  = pend_last_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    push_s       = 1'b0;
    push_word_s  = pack_q;
    push_last_s  = 1'b0;
    last_samp_s  = (rem_q == CNT_W'(1));

    // Drain first: a transfer frees the output register and promotes pending.
    xfer_s = out_valid_q & ~out_full;
    if (xfer_s) begin
      if (pend_valid_q) begin
        out_word_d = pend_word_q;
        out_last_d = pend_last_q;
      end else begin
        out_word_d = out_word_q;
        out_last_d = out_last_q;
      end
      out_valid_d  = pend_valid_q;
      pend_valid_d = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
      pend_valid_d = pend_valid_q;
    end
    can_push_s = ~out_valid_d | ~pend_valid_d;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lsel_d    = (lane_sel > LSEL_MAX_C) ? LSEL_MAX_C : lane_sel;
          rem_d     = sample_cycles;
          pack_d    = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = (sample_cycles == '0) ? S_FLUSH : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (samp_vld) begin
          rem_d = rem_q - CNT_W'(1);
          if (cnt_q + ONE_C == word_samps_s) begin
            if (can_push_s) begin
              push_s      = 1'b1;
              push_word_s = pack_q | samp_bits_s;
              push_last_s = last_samp_s;
              pack_d      = '0;
              cnt_d       = '0;
            end else begin
              // Dropped: packer keeps its partial contents for the next sample.
              overrun_d = 1'b1;
            end
          end else begin
            pack_d = pack_q | samp_bits_s;
            cnt_d  = cnt_q + ONE_C;
          end
          state_d = last_samp_s ? S_FLUSH : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (cnt_q != '0) begin
          if (can_push_s) begin
            push_s      = 1'b1;
            push_word_s = pack_q;
            push_last_s = 1'b1;
            pack_d      = '0;
            cnt_d       = '0;
          end else begin
            push_s = 1'b0;
          end
        end else if (~out_valid_d & ~pend_valid_d) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Place a new word behind whatever survives the drain.
    if (push_s) begin
      if (~out_valid_d) begin
        out_valid_d = 1'b1;
        out_word_d  = push_word_s;
        out_last_d  = push_last_s;
      end else begin
        pend_valid_d = 1'b1;
        pend_word_d  = push_word_s;
        pend_last_d  = push_last_s;
      end
    end else begin
      pend_word_d = pend_word_d;
    end

    if (abort) begin
      state_d      = S_IDLE;
      pack_d       = '0;
      cnt_d        = '0;
      out_valid_d  = 1'b0;
      out_word_d   = '0;
      out_last_d   = 1'b0;
      pend_valid_d = 1'b0;
      pend_word_d  = '0;
      pend_last_d  = 1'b0;
      done_d       = 1'b0;
      overrun_d    = overrun_q;
    end else begin
      overrun_d = overrun_d;
    end

    // busy stays high through the done pulse and falls with it.
    busy_d = (state_d != S_IDLE) | done_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lsel_q       <= 3'd0;
      rem_q        <= '0;
      pack_q       <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      out_last_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      pend_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lsel_q       <= lsel_d;
      rem_q        <= rem_d;
      pack_q       <= pack_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_last_q   <= out_last_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      pend_last_q  <= pend_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
